// File: rtl/stack_lifo.sv
// stack_lifo: show-ahead LIFO stack (CLK, RST, PUSH, POP, DATA_IN -> DATA_OUT, FULL, EMPTY; sticky OVERFLOW/UNDERFLOW with STACK_ERR_EN)
module stack_lifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             FULL,
  output logic             EMPTY
`ifdef STACK_ERR_EN
  ,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] top;
  logic [AW-1:0] wa;
  logic we;
  logic inc;
  logic dec;
  always_comb begin
    FULL = cnt == CW'(DEPTH);
    EMPTY = cnt == '0;
    top = AW'(cnt - CW'(1));
    wa = (POP && !EMPTY) ? top : AW'(cnt);
    we = !RST && PUSH && (POP || !FULL);
    inc = PUSH && (POP ? EMPTY : !FULL);
    dec = POP && !PUSH && !EMPTY;
    DATA_OUT = EMPTY ? '0 : mem[top];
  end
  always_ff @(posedge CLK) begin
    if (we) mem[wa] <= DATA_IN;
  end
  always_ff @(posedge CLK) begin
    if (RST) cnt <= '0;
    else if (inc) cnt <= cnt + CW'(1);
    else if (dec) cnt <= cnt - CW'(1);
  end
`ifdef STACK_ERR_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= OVERFLOW | (PUSH && !POP && FULL);
      UNDERFLOW <= UNDERFLOW | (POP && !PUSH && EMPTY);
    end
  end
`endif
endmodule

// File: tb/tb_stack_lifo.sv
// tb_stack_lifo: randomized and directed checks of stack_lifo against a queue-based model
module tb_stack_lifo;
  localparam int W = 2;
  localparam int D = 8;
`ifdef STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic PUSH = 1'b0;
  logic POP = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic [W-1:0] DATA_OUT;
  logic FULL;
  logic EMPTY;
  logic ovf;
  logic unf;
  logic [W+3:0] st;
  int passed = 0;
  int total = 0;
  logic [W-1:0] q[$];
  bit m_ovf;
  bit m_unf;
  always #5 CLK = ~CLK;
  stack_lifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK),
    .RST(RST),
    .PUSH(PUSH),
    .POP(POP),
    .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT),
    .FULL(FULL),
    .EMPTY(EMPTY)
`ifdef STACK_ERR_EN
    ,
    .OVERFLOW(ovf),
    .UNDERFLOW(unf)
`endif
  );
`ifndef STACK_ERR_EN
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
  assign st = {DATA_OUT, FULL, EMPTY, ovf, unf};
  function automatic logic [W+3:0] exp_st();
    logic [W-1:0] t;
    t = q.size() > 0 ? q[q.size()-1] : '0;
    return {t, q.size() == D, q.size() == 0, ERR & m_ovf, ERR & m_unf};
  endfunction
  task automatic step(input bit push, input bit pop, input logic [W-1:0] din, input bit rst);
    PUSH = push;
    POP = pop;
    DATA_IN = din;
    RST = rst;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (push && pop) begin
      if (q.size() > 0) q[q.size()-1] = din;
      else q.push_back(din);
    end else if (push) begin
      if (q.size() < D) q.push_back(din);
      else m_ovf = 1;
    end else if (pop) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1;
    end
    #1;
    PUSH = 0;
    POP = 0;
    RST = 0;
  endtask
  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    total++; if (EMPTY !== 1'b1) $display("FAIL reset_empty: got %b want 1", EMPTY); else passed++;
    total++; if (FULL !== 1'b0) $display("FAIL reset_full: got %b want 0", FULL); else passed++;
    total++; if (DATA_OUT !== 2'd0) $display("FAIL reset_data: got %0d want 0", DATA_OUT); else passed++;
    total++; if ({ovf, unf} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ovf, unf}); else passed++;
  endtask
  task automatic test_push_pop();
    logic [W-1:0] want;
    step(0, 0, 0, 1);
    for (int v = 1; v <= 3; v++) step(1, 0, W'(v), 0);
    total++; if (DATA_OUT !== 2'd3) $display("FAIL pp_top: got %0d want 3", DATA_OUT); else passed++;
    total++; if (EMPTY !== 1'b0) $display("FAIL pp_empty: got %b want 0", EMPTY); else passed++;
    for (int i = 2; i >= 0; i--) begin
      step(0, 1, 0, 0);
      want = W'(i);
      total++; if (DATA_OUT !== want) $display("FAIL pp_pop%0d: got %0d want %0d", i, DATA_OUT, want); else passed++;
    end
    total++; if (EMPTY !== 1'b1) $display("FAIL pp_final_empty: got %b want 1", EMPTY); else passed++;
  endtask
  task automatic test_fill();
    logic [W-1:0] top;
    step(0, 0, 0, 1);
    for (int i = 0; i < D; i++) begin
      step(1, 0, W'($urandom), 0);
      if (i == D - 2) begin
        total++; if (FULL !== 1'b0) $display("FAIL fill_not_full: got %b want 0", FULL); else passed++;
      end
    end
    total++; if (FULL !== 1'b1) $display("FAIL fill_full: got %b want 1", FULL); else passed++;
    top = q[q.size()-1];
    step(1, 0, 0, 0);
    total++; if (DATA_OUT !== top) $display("FAIL fill_ovf_data: got %0d want %0d", DATA_OUT, top); else passed++;
    total++; if (FULL !== 1'b1) $display("FAIL fill_ovf_full: got %b want 1", FULL); else passed++;
    total++; if (ovf !== ERR) $display("FAIL fill_ovf_flag: got %b want %b", ovf, ERR); else passed++;
    for (int i = 0; i < D; i++) begin
      step(0, 1, 0, 0);
      total++; if (st !== exp_st()) $display("FAIL fill_drain%0d: got %h want %h", i, st, exp_st()); else passed++;
    end
  endtask
  task automatic test_empty_pop();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    total++; if (EMPTY !== 1'b1) $display("FAIL epop_empty: got %b want 1", EMPTY); else passed++;
    total++; if (DATA_OUT !== 2'd0) $display("FAIL epop_data: got %0d want 0", DATA_OUT); else passed++;
    total++; if (unf !== ERR) $display("FAIL epop_unf: got %b want %b", unf, ERR); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL epop_ovf: got %b want 0", ovf); else passed++;
    step(0, 0, 0, 1);
    total++; if (unf !== 1'b0) $display("FAIL epop_unf_clr: got %b want 0", unf); else passed++;
  endtask
  task automatic test_simultaneous();
    step(0, 0, 0, 1);
    step(1, 0, 2'd1, 0);
    step(1, 0, 2'd2, 0);
    step(1, 1, 2'd3, 0);
    total++; if (DATA_OUT !== 2'd3) $display("FAIL sim_top: got %0d want 3", DATA_OUT); else passed++;
    step(0, 1, 0, 0);
    total++; if (DATA_OUT !== 2'd1) $display("FAIL sim_pop1: got %0d want 1", DATA_OUT); else passed++;
    step(0, 1, 0, 0);
    total++; if (EMPTY !== 1'b1) $display("FAIL sim_pop2_empty: got %b want 1", EMPTY); else passed++;
    step(0, 0, 0, 1);
    step(1, 1, 2'd3, 0);
    total++; if (DATA_OUT !== 2'd3) $display("FAIL sim_empty_top: got %0d want 3", DATA_OUT); else passed++;
    total++; if (EMPTY !== 1'b0) $display("FAIL sim_empty_flag: got %b want 0", EMPTY); else passed++;
    for (int i = 1; i < D; i++) step(1, 0, 2'd0, 0);
    step(1, 1, 2'd2, 0);
    total++; if ({DATA_OUT, FULL, ovf} !== {2'd2, 1'b1, 1'b0}) $display("FAIL sim_full_replace: got %h want %h", {DATA_OUT, FULL, ovf}, {2'd2, 1'b1, 1'b0}); else passed++;
    step(0, 1, 0, 0);
    total++; if (st !== exp_st()) $display("FAIL sim_full_pop: got %h want %h", st, exp_st()); else passed++;
  endtask
  task automatic test_reset_mid();
    step(0, 0, 0, 1);
    for (int i = 0; i < D / 2; i++) step(1, 0, W'(i + 1), 0);
    step(1, 0, 2'd3, 1);
    total++; if (EMPTY !== 1'b1) $display("FAIL rmid_empty: got %b want 1", EMPTY); else passed++;
    total++; if (DATA_OUT !== 2'd0) $display("FAIL rmid_data: got %0d want 0", DATA_OUT); else passed++;
    step(0, 0, 0, 0);
    total++; if (st !== exp_st()) $display("FAIL rmid_hold: got %h want %h", st, exp_st()); else passed++;
  endtask
  task automatic test_random();
    int bias;
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias, W'($urandom), $urandom_range(0, 79) == 0);
      total++; if (st !== exp_st()) $display("FAIL rand%0d: got %h want %h", i, st, exp_st()); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_push_pop();
    test_fill();
    test_empty_pop();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
